// File: rtl/l2_neuron_seq.sv
// Sequential neuron y = act(b + sum x[i]*w[i]) using one shared multiplier. Result is valid N cycles after accept.
// No overlap between operations: in_ready is low from accept until the result leaves. y and sat hold while out_ready is low.
module l2_neuron_seq #(
  parameter  int N     = 4,
  parameter  int WIDTH = 8,
  localparam int ACC_W = 2*WIDTH + $clog2(N) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] x,
  input  logic [N*WIDTH-1:0] w,
  input  logic [WIDTH-1:0]   b,
  input  logic               act_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y,
  output logic               sat
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N-1);
  localparam logic signed [ACC_W-1:0] MAXV = $signed({{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] MINV = $signed({{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}});

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                    state_q, state_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic [N*WIDTH-1:0]        x_q, x_d;
  logic [N*WIDTH-1:0]        w_q, w_d;
  logic                      lin_q, lin_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]          y_q, y_d;
  logic                      sat_q, sat_d;

  logic                      accept;
  logic                      last_mac;
  logic signed [WIDTH-1:0]   x_sel, w_sel;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   act_r;
  logic                      over, under;

  assign accept   = in_valid && in_ready_q;
  assign last_mac = (idx_q == LAST_IDX);

  assign x_sel    = x_q[int'(idx_q)*WIDTH +: WIDTH];
  assign w_sel    = w_q[int'(idx_q)*WIDTH +: WIDTH];
  assign prod     = x_sel * w_sel;
  assign prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign sum      = acc_q + prod_ext;

  // ReLU zeroes negatives before clamping, so only the upper bound can clip in that mode.
  assign act_r = (!lin_q && sum[ACC_W-1]) ? '0 : sum;
  assign over  = (act_r > MAXV);
  assign under = (act_r < MINV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept)    state_d = S_MAC;
      S_MAC:   if (last_mac)  state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_OUT);
    x_d   = x_q;
    w_d   = w_q;
    lin_d = lin_q;
    idx_d = idx_q;
    acc_d = acc_q;
    y_d   = y_q;
    sat_d = sat_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d   = x;
          w_d   = w;
          lin_d = act_mode;
          acc_d = {{(ACC_W-WIDTH){b[WIDTH-1]}}, b};
          idx_d = '0;
        end
      end
      S_MAC: begin
        acc_d = sum;
        idx_d = idx_q + 1'b1;
        if (last_mac) begin
          if (over)       y_d = {1'b0, {(WIDTH-1){1'b1}}};
          else if (under) y_d = {1'b1, {(WIDTH-1){1'b0}}};
          else            y_d = act_r[WIDTH-1:0];
          sat_d = over || under;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      w_q   <= '0;
      lin_q <= 1'b0;
      idx_q <= '0;
      acc_q <= '0;
      y_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      w_q   <= w_d;
      lin_q <= lin_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      y_q   <= y_d;
      sat_q <= sat_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign sat       = sat_q;

  a_hold_out: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(y) && $stable(sat)));
  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n) !(in_ready && out_valid));

endmodule

// File: tb/tb_l2_neuron_seq.sv
// Bench for l2_neuron_seq: three instances (N=4/W=8, N=1/W=12, N=8/W=12) checked against an integer reference model.
// A negedge monitor compares every valid output; directed cases also pin literal results.
module tb_l2_neuron_seq;
  typedef int arr_t [8];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] in_valid_v, in_ready_v, out_valid_v, out_ready_v, mode_v, sat_v;
  logic [95:0] x_v [3];
  logic [95:0] w_v [3];
  logic [11:0] b_v [3];
  logic [7:0]  y0;
  logic [11:0] y1, y2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int NN [3] = '{4, 1, 8};
  int WW [3] = '{8, 12, 12};

  bit pending [3];
  bit seen [3];
  int exp_y [3];
  bit exp_s [3];
  int acc_edge [3];
  int stage_y [3];
  bit stage_s [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  l2_neuron_seq #(.N(4), .WIDTH(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .x(x_v[0][31:0]), .w(w_v[0][31:0]), .b(b_v[0][7:0]), .act_mode(mode_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .y(y0), .sat(sat_v[0]));

  l2_neuron_seq #(.N(1), .WIDTH(12)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .x(x_v[1][11:0]), .w(w_v[1][11:0]), .b(b_v[1]), .act_mode(mode_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .y(y1), .sat(sat_v[1]));

  l2_neuron_seq #(.N(8), .WIDTH(12)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .x(x_v[2]), .w(w_v[2]), .b(b_v[2]), .act_mode(mode_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .y(y2), .sat(sat_v[2]));

  function automatic int get_y(int d);
    case (d)
      0:       return int'($signed(y0));
      1:       return int'($signed(y1));
      default: return int'($signed(y2));
    endcase
  endfunction

  // Reference: exact integer dot product, activation, then clamp to the signed output range.
  function automatic void model(int n, int wd, arr_t xs, arr_t ws, int bb, bit lin,
                                output int yo, output bit so);
    longint s, r, maxv, minv;
    s = longint'(bb);
    for (int i = 0; i < n; i++) s += longint'(xs[i]) * longint'(ws[i]);
    r = lin ? s : ((s > 0) ? s : 0);
    maxv = (longint'(1) << (wd-1)) - 1;
    minv = -(longint'(1) << (wd-1));
    so = (r > maxv) || (r < minv);
    yo = int'((r > maxv) ? maxv : ((r < minv) ? minv : r));
  endfunction

  function automatic logic [95:0] pack(arr_t a, int n, int wd);
    logic [95:0] p, m;
    p = '0;
    m = (96'd1 << wd) - 96'd1;
    for (int i = 0; i < n; i++) p = p | ((96'(a[i]) & m) << (i*wd));
    return p;
  endfunction

  function automatic int rv(int wd);
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return -(1 << (wd-1));
    if (r == 1) return (1 << (wd-1)) - 1;
    return int'($urandom_range(0, (1 << wd) - 1)) - (1 << (wd-1));
  endfunction

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired, got no event, required one (t=%0t)", name, $time);
  endtask

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        pending[d] = 1'b0;
        seen[d] = 1'b0;
      end else begin
        if (pending[d] && !out_valid_v[d]) chk("busy_in_ready", int'(in_ready_v[d]), 0);
        if (out_valid_v[d]) begin
          if (!pending[d]) begin
            chk("spurious_out_valid", 1, 0);
          end else begin
            if (!seen[d]) begin
              seen[d] = 1'b1;
              chk("latency", cyc - acc_edge[d], NN[d]);
            end
            chk("y", get_y(d), exp_y[d]);
            chk("sat", int'(sat_v[d]), int'(exp_s[d]));
            chk("out_in_ready", int'(in_ready_v[d]), 0);
            if (out_ready_v[d]) begin
              pending[d] = 1'b0;
              seen[d] = 1'b0;
            end
          end
        end
        if (in_valid_v[d] && in_ready_v[d]) begin
          pending[d]  = 1'b1;
          seen[d]     = 1'b0;
          exp_y[d]    = stage_y[d];
          exp_s[d]    = stage_s[d];
          acc_edge[d] = cyc + 1;
        end
      end
    end
  end

  task automatic start_op(int d, arr_t xs, arr_t ws, int bb, bit lin);
    int ey;
    bit es;
    int t;
    model(NN[d], WW[d], xs, ws, bb, lin, ey, es);
    stage_y[d] = ey;
    stage_s[d] = es;
    x_v[d] = pack(xs, NN[d], WW[d]);
    w_v[d] = pack(ws, NN[d], WW[d]);
    b_v[d] = 12'(bb);
    mode_v[d] = lin;
    in_valid_v[d] = 1'b1;
    t = 0;
    while (!in_ready_v[d] && t < 40) begin
      wait_edge();
      t++;
    end
    if (!in_ready_v[d]) timeout("accept_wait");
    wait_edge();
    in_valid_v[d] = 1'b0;
    x_v[d] = {$urandom, $urandom, $urandom};
    w_v[d] = {$urandom, $urandom, $urandom};
    b_v[d] = 12'($urandom);
    mode_v[d] = 1'($urandom);
  endtask

  task automatic finish_op(int d, int hold, output int yo, output bit so);
    int t;
    t = 0;
    while (!out_valid_v[d] && t < 40) begin
      wait_edge();
      t++;
    end
    if (!out_valid_v[d]) timeout("out_valid_wait");
    yo = get_y(d);
    so = sat_v[d];
    repeat (hold) wait_edge();
    out_ready_v[d] = 1'b1;
    wait_edge();
    out_ready_v[d] = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    in_valid_v = '0;
    out_ready_v = '0;
    #1;
    chk("rst_out_valid", int'(out_valid_v), 0);
    chk("rst_in_ready", int'(in_ready_v), 0);
    chk("rst_sat", int'(sat_v), 0);
    chk("rst_y0", get_y(0), 0);
    chk("rst_y1", get_y(1), 0);
    chk("rst_y2", get_y(2), 0);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_before_edge", int'(in_ready_v), 0);
    wait_edge();
    chk("rel_in_ready_after_edge", int'(in_ready_v), 7);
  endtask

  task automatic run_rand(int d, int count);
    arr_t xs, ws;
    int yo;
    bit so;
    for (int k = 0; k < count; k++) begin
      for (int i = 0; i < 8; i++) begin
        xs[i] = rv(WW[d]);
        ws[i] = rv(WW[d]);
      end
      start_op(d, xs, ws, rv(WW[d]), 1'($urandom));
      finish_op(d, int'($urandom_range(0, 3)), yo, so);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arr_t dx [9];
    arr_t dw [9];
    int   db [9];
    bit   dm [9];
    int   dy [9];
    bit   ds [9];
    arr_t zx, px, pw;
    int yo, my;
    bit so, ms;

    in_valid_v = '0;
    out_ready_v = '0;
    mode_v = '0;
    for (int d = 0; d < 3; d++) begin
      x_v[d] = '0;
      w_v[d] = '0;
      b_v[d] = '0;
    end
    zx = '{0, 0, 0, 0, 0, 0, 0, 0};

    #12;
    apply_reset();

    // Pin the model on hand-computed 12-bit cases.
    px = '{-2048, 0, 0, 0, 0, 0, 0, 0};
    model(1, 12, px, px, 0, 1'b1, my, ms);
    chk("pin_n1_y", my, 2047);
    chk("pin_n1_sat", int'(ms), 1);
    px = '{3, 3, 3, 3, 3, 3, 3, 3};
    pw = '{5, 5, 5, 5, 5, 5, 5, 5};
    model(8, 12, px, pw, -1, 1'b1, my, ms);
    chk("pin_n8_y", my, 119);
    chk("pin_n8_sat", int'(ms), 0);

    dx[0] = '{1, 2, 3, 4, 0, 0, 0, 0};         dw[0] = '{1, 1, 1, 1, 0, 0, 0, 0};
    db[0] = 0;    dm[0] = 1'b0; dy[0] = 10;   ds[0] = 1'b0;
    dx[1] = dx[0];                             dw[1] = '{-1, -1, -1, -1, 0, 0, 0, 0};
    db[1] = 0;    dm[1] = 1'b0; dy[1] = 0;    ds[1] = 1'b0;
    dx[2] = dx[0];                             dw[2] = dw[1];
    db[2] = 0;    dm[2] = 1'b1; dy[2] = -10;  ds[2] = 1'b0;
    dx[3] = '{127, 127, 127, 127, 0, 0, 0, 0}; dw[3] = dx[3];
    db[3] = 127;  dm[3] = 1'b0; dy[3] = 127;  ds[3] = 1'b1;
    dx[4] = '{-128, -128, -128, -128, 0, 0, 0, 0}; dw[4] = dx[3];
    db[4] = -128; dm[4] = 1'b1; dy[4] = -128; ds[4] = 1'b1;
    dx[5] = dx[3];                             dw[5] = dx[4];
    db[5] = 0;    dm[5] = 1'b0; dy[5] = 0;    ds[5] = 1'b0;
    dx[6] = '{127, 0, 0, 0, 0, 0, 0, 0};       dw[6] = '{1, 0, 0, 0, 0, 0, 0, 0};
    db[6] = 0;    dm[6] = 1'b1; dy[6] = 127;  ds[6] = 1'b0;
    dx[7] = '{-128, 0, 0, 0, 0, 0, 0, 0};      dw[7] = dw[6];
    db[7] = 0;    dm[7] = 1'b1; dy[7] = -128; ds[7] = 1'b0;
    dx[8] = dx[7];                             dw[8] = dw[6];
    db[8] = -1;   dm[8] = 1'b1; dy[8] = -128; ds[8] = 1'b1;

    for (int i = 0; i < 9; i++) begin
      start_op(0, dx[i], dw[i], db[i], dm[i]);
      finish_op(0, 0, yo, so);
      chk("dir_y", yo, dy[i]);
      chk("dir_sat", int'(so), int'(ds[i]));
    end

    // Backpressure for 5 cycles, then the next operation goes in on the very next edge.
    start_op(0, dx[0], dw[0], 0, 1'b0);
    finish_op(0, 5, yo, so);
    chk("bp_y", yo, 10);
    chk("b2b_in_ready", int'(in_ready_v[0]), 1);
    start_op(0, zx, zx, 5, 1'b0);
    finish_op(0, 0, yo, so);
    chk("b2b_y", yo, 5);

    // Reset two cycles into MAC, then a clean operation.
    pw = '{2, 2, 2, 2, 0, 0, 0, 0};
    start_op(0, dx[0], pw, 3, 1'b1);
    wait_edge();
    wait_edge();
    #2;
    apply_reset();
    start_op(0, dx[0], pw, 3, 1'b1);
    finish_op(0, 0, yo, so);
    chk("post_rst_y", yo, 23);

    // Reset while the result is being presented.
    start_op(0, dx[0], dw[0], 0, 1'b0);
    for (int t = 0; t < 20 && !out_valid_v[0]; t++) wait_edge();
    chk("out_before_rst", int'(out_valid_v[0]), 1);
    #2;
    apply_reset();

    fork
      run_rand(0, 30);
      run_rand(1, 30);
      run_rand(2, 30);
    join

    repeat (3) wait_edge();
    for (int d = 0; d < 3; d++) chk("drained", int'(pending[d]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
